// File: rtl/aes_blk_packer.sv
// aes_blk_packer: packs a 32-bit word stream into 128-bit blocks for the AES
// core input port. Messages are closed with PKCS#7 padding at word
// granularity (or zero fill when PAD_EN=0). Each block is then held on a
// valid/ready port until the core accepts it.
module aes_blk_packer #(
  parameter int unsigned PAD_EN = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         s_vld,
  input  logic [31:0]  s_data,
  input  logic         s_last,
  output logic         s_rdy,
  output logic         m_vld,
  output logic [127:0] m_data,
  output logic         m_last,
  input  logic         m_rdy,
  output logic [15:0]  blk_cnt
);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    HOLD = 2'd1,
    PAD  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [1:0]     widx_q, widx_d;
  logic [127:0]   data_q, data_d;
  logic           last_q, last_d;
  logic           pad_pend_q, pad_pend_d;
  logic [15:0]    blk_cnt_q, blk_cnt_d;

  // Pad byte for a message closing at word index widx: 4 * (3 - widx),
  // i.e. 0x0C/0x08/0x04 for 1/2/3 words already in the block.
  logic [1:0]     widx_inv;
  logic [7:0]     pad_byte;
  logic [31:0]    pad_word;

  assign widx_inv = 2'd3 - widx_q;
  assign pad_byte = {4'h0, widx_inv, 2'b00};
  assign pad_word = (PAD_EN != 0) ? {4{pad_byte}} : 32'h0;

  assign s_rdy   = (state_q == FILL) & ~flush;
  assign m_vld   = (state_q == HOLD) | (state_q == PAD);
  assign m_data  = data_q;
  assign m_last  = last_q;
  assign blk_cnt = blk_cnt_q;

  // Next-state, block assembly, padding and handoff counting.
  always_comb begin
    state_d    = state_q;
    widx_d     = widx_q;
    data_d     = data_q;
    last_d     = last_q;
    pad_pend_d = pad_pend_q;
    blk_cnt_d  = blk_cnt_q;

    if (flush) begin
      // Abort wins over everything: any partial or presented block is lost.
      state_d    = FILL;
      widx_d     = 2'd0;
      pad_pend_d = 1'b0;
      last_d     = 1'b0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (s_vld) begin
            for (int i = 0; i < 4; i++) begin
              if (i == int'(widx_q)) begin
                data_d[32*(3-i) +: 32] = s_data;
              end else if (s_last && (i > int'(widx_q))) begin
                data_d[32*(3-i) +: 32] = pad_word;
              end
            end
            if (s_last) begin
              state_d = HOLD;
              widx_d  = 2'd0;
              if ((widx_q == 2'd3) && (PAD_EN != 0)) begin
                // Block-aligned message end: an extra full pad block follows.
                last_d     = 1'b0;
                pad_pend_d = 1'b1;
              end else begin
                last_d = 1'b1;
              end
            end else if (widx_q == 2'd3) begin
              state_d = HOLD;
              widx_d  = 2'd0;
              last_d  = 1'b0;
            end else begin
              widx_d = widx_q + 2'd1;
            end
          end
        end

        HOLD: begin
          if (m_rdy) begin
            blk_cnt_d = blk_cnt_q + 16'd1;
            if (pad_pend_q) begin
              state_d = PAD;
              data_d  = {16{8'h10}};
              last_d  = 1'b1;
            end else begin
              state_d = FILL;
              last_d  = 1'b0;
            end
          end
        end

        PAD: begin
          if (m_rdy) begin
            blk_cnt_d  = blk_cnt_q + 16'd1;
            pad_pend_d = 1'b0;
            state_d    = FILL;
            last_d     = 1'b0;
          end
        end

        default: begin
          state_d = FILL;
          widx_d  = 2'd0;
          last_d  = 1'b0;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and bookkeeping registers; all return to zero on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      widx_q     <= 2'd0;
      data_q     <= 128'h0;
      last_q     <= 1'b0;
      pad_pend_q <= 1'b0;
      blk_cnt_q  <= 16'h0;
    end else begin
      widx_q     <= widx_d;
      data_q     <= data_d;
      last_q     <= last_d;
      pad_pend_q <= pad_pend_d;
      blk_cnt_q  <= blk_cnt_d;
    end
  end

endmodule
